// File: rtl/decode_stage.sv
// Registered opcode decode stage with HALT/RUN FSM, flush and handshake.
// Optional load-use interlock: define LOAD_USE_INTERLOCK_EN.
module decode_stage #(
    parameter  int RA_W = 4,
    localparam int IW   = 4 + 3 * RA_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IW-1:0]   instr,
    input  logic            flush,
    input  logic            resume,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [RA_W-1:0] DA,
    output logic [RA_W-1:0] AA,
    output logic [RA_W-1:0] BA,
    output logic [2:0]      FS,
    output logic            RW,
    output logic            MB,
    output logic            MD,
    output logic            MJ,
    output logic            MM,
    output logic            MW,
    output logic            MK,
    output logic            A_thru,
    output logic            B_thru,
    output logic            illegal,
    output logic            halted
);

    typedef enum logic {RUN, HALT} state_t;

    typedef struct packed {
        logic [2:0] fs;
        logic       rw;
        logic       mb;
        logic       md;
        logic       mj;
        logic       mm;
        logic       mw;
        logic       mk;
        logic       a_thru;
        logic       b_thru;
        logic       ill;
    } ctrl_t;

    state_t          state_q, state_d;
    logic            valid_q, valid_d;
    ctrl_t           ctrl_q, ctrl_d, dec;
    logic [RA_W-1:0] da_q, da_d;
    logic [RA_W-1:0] aa_q, aa_d;
    logic [RA_W-1:0] ba_q, ba_d;

    logic [3:0]      op;
    logic [RA_W-1:0] da_in, aa_in, ba_in;
    logic            is_halt;
    logic            hazard;
    logic            accept;

    assign op    = instr[IW-1 -: 4];
    assign da_in = instr[3*RA_W-1 -: RA_W];
    assign aa_in = instr[2*RA_W-1 -: RA_W];
    assign ba_in = instr[RA_W-1:0];

    assign is_halt = (op == 4'hF) && (da_in == {RA_W{1'b1}});

    always_comb begin
        dec = '0;
        unique case (1'b1)
            (!op[3]): begin
                dec.rw = 1'b1;
                dec.fs = op[2:0];
            end
            (op == 4'h8): begin
                dec.rw     = 1'b1;
                dec.mb     = 1'b1;
                dec.b_thru = 1'b1;
            end
            (op == 4'h9): begin
                dec.rw = 1'b1;
                dec.md = 1'b1;
                dec.mm = 1'b1;
            end
            (op == 4'hA): begin
                dec.mw = 1'b1;
                dec.mm = 1'b1;
            end
            (op == 4'hB), (op == 4'hC): begin
                dec.mk     = 1'b1;
                dec.a_thru = 1'b1;
            end
            (op == 4'hD): begin
                dec.rw = 1'b1;
                dec.mj = 1'b1;
            end
            (op == 4'hE): begin
                dec = '0;
            end
            default: begin
                // 1111: NOP and HALT are legal, any other DA is not
                dec.ill = (da_in != '0) && !is_halt;
            end
        endcase
    end

`ifdef LOAD_USE_INTERLOCK_EN
    assign hazard = in_valid && valid_q && ctrl_q.md &&
                    ((aa_in == da_q) || (ba_in == da_q));
`else
    assign hazard = 1'b0;
`endif

    assign in_ready = !rst && !flush && (state_q == RUN) &&
                      !hazard && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        da_d    = da_q;
        aa_d    = aa_q;
        ba_d    = ba_q;
        if (flush) begin
            valid_d = 1'b0;
            state_d = RUN;
        end else begin
            if (accept) begin
                valid_d = 1'b1;
                ctrl_d  = dec;
                da_d    = da_in;
                aa_d    = aa_in;
                ba_d    = ba_in;
            end else if (valid_q && out_ready) begin
                valid_d = 1'b0;
            end
            unique case (state_q)
                RUN:     if (accept && is_halt) state_d = HALT;
                HALT:    if (resume) state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            da_q    <= '0;
            aa_q    <= '0;
            ba_q    <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            da_q    <= da_d;
            aa_q    <= aa_d;
            ba_q    <= ba_d;
        end
    end

    assign out_valid = valid_q;
    assign DA        = da_q;
    assign AA        = aa_q;
    assign BA        = ba_q;
    assign FS        = ctrl_q.fs;
    assign RW        = ctrl_q.rw;
    assign MB        = ctrl_q.mb;
    assign MD        = ctrl_q.md;
    assign MJ        = ctrl_q.mj;
    assign MM        = ctrl_q.mm;
    assign MW        = ctrl_q.mw;
    assign MK        = ctrl_q.mk;
    assign A_thru    = ctrl_q.a_thru;
    assign B_thru    = ctrl_q.b_thru;
    assign illegal   = ctrl_q.ill;
    assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_decode_stage.sv
// Directed table-driven bench for decode_stage plus corner sequences.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, resume;
    logic        out_valid, out_ready;
    logic [15:0] instr;
    logic [3:0]  DA, AA, BA;
    logic [2:0]  FS;
    logic        RW, MB, MD, MJ, MM, MW, MK, A_thru, B_thru;
    logic        illegal, halted;

    int tests = 0;
    int fails = 0;

    decode_stage #(.RA_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .flush(flush), .resume(resume),
        .out_valid(out_valid), .out_ready(out_ready),
        .DA(DA), .AA(AA), .BA(BA), .FS(FS),
        .RW(RW), .MB(MB), .MD(MD), .MJ(MJ), .MM(MM),
        .MW(MW), .MK(MK), .A_thru(A_thru), .B_thru(B_thru),
        .illegal(illegal), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [2:0]  fs;
        logic [8:0]  ctrl;
        logic        ill;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [8:0] ctrl_now();
        return {RW, MB, MD, MJ, MM, MW, MK, A_thru, B_thru};
    endfunction

    task automatic chk(input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++)
            vecs[i] = '{{i[3:0], 4'h1, 4'h2, 4'h4}, i[2:0], 9'h100, 1'b0};
        vecs[8]  = '{16'h8567, 3'd0, 9'b110000001, 1'b0};
        vecs[9]  = '{16'h9A00, 3'd0, 9'b101010000, 1'b0};
        vecs[10] = '{16'hA500, 3'd0, 9'b000011000, 1'b0};
        vecs[11] = '{16'hB123, 3'd0, 9'b000000110, 1'b0};
        vecs[12] = '{16'hC321, 3'd0, 9'b000000110, 1'b0};
        vecs[13] = '{16'hD777, 3'd0, 9'b100100000, 1'b0};
        vecs[14] = '{16'hE888, 3'd0, 9'b000000000, 1'b0};
        vecs[15] = '{16'hF512, 3'd0, 9'b000000000, 1'b1};

        rst = 1'b1; in_valid = 1'b0; instr = '0;
        flush = 1'b0; resume = 1'b0; out_ready = 1'b1;
        step();
        in_valid = 1'b1;
        #1;
        chk("rst_in_ready", {15'b0, in_ready}, 16'd0);
        step();
        chk("rst_valid", {15'b0, out_valid}, 16'd0);
        chk("rst_ctrl", {7'b0, ctrl_now()}, 16'd0);
        chk("rst_fs", {13'b0, FS}, 16'd0);
        chk("rst_regs", {4'b0, DA, AA, BA}, 16'd0);
        chk("rst_ill_halt", {14'b0, illegal, halted}, 16'd0);
        rst = 1'b0; in_valid = 1'b0;
        step();

        for (int i = 0; i < 16; i++) begin
            instr = vecs[i].instr;
            in_valid = 1'b1;
            #1;
            chk($sformatf("v%0d_ready", i), {15'b0, in_ready}, 16'd1);
            step();
            chk($sformatf("v%0d_valid", i), {15'b0, out_valid}, 16'd1);
            chk($sformatf("v%0d_fs", i), {13'b0, FS}, {13'b0, vecs[i].fs});
            chk($sformatf("v%0d_ctrl", i), {7'b0, ctrl_now()},
                {7'b0, vecs[i].ctrl});
            chk($sformatf("v%0d_regs", i), {4'b0, DA, AA, BA},
                {4'b0, vecs[i].instr[11:0]});
            chk($sformatf("v%0d_ill_halt", i), {14'b0, illegal, halted},
                {14'b0, vecs[i].ill, 1'b0});
        end
        in_valid = 1'b0;
        step();
        chk("drain_valid", {15'b0, out_valid}, 16'd0);

        instr = 16'h9300; in_valid = 1'b1;
        #1;
        step();
        chk("lu_load_md", {15'b0, MD}, 16'd1);
        instr = 16'h0530;
        #1;
`ifdef LOAD_USE_INTERLOCK_EN
        chk("lu_stall_ready", {15'b0, in_ready}, 16'd0);
        step();
        chk("lu_bubble", {15'b0, out_valid}, 16'd0);
        chk("lu_after_ready", {15'b0, in_ready}, 16'd1);
        step();
`else
        chk("lu_noint_ready", {15'b0, in_ready}, 16'd1);
        step();
`endif
        chk("lu_use_valid", {15'b0, out_valid}, 16'd1);
        chk("lu_use_ctrl", {7'b0, ctrl_now()}, 16'h100);
        chk("lu_use_aa", {12'b0, AA}, 16'd3);
        in_valid = 1'b0;
        step();

        instr = 16'hFF00; in_valid = 1'b1;
        #1;
        step();
        chk("halt_valid", {15'b0, out_valid}, 16'd1);
        chk("halt_flag", {15'b0, halted}, 16'd1);
        chk("halt_ctrl", {6'b0, illegal, ctrl_now()}, 16'd0);
        instr = 16'h0123;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("halt_ready%0d", k), {15'b0, in_ready}, 16'd0);
            step();
        end
        chk("halt_drained", {15'b0, out_valid}, 16'd0);
        chk("halt_still", {15'b0, halted}, 16'd1);
        resume = 1'b1;
        #1;
        chk("resume_ready", {15'b0, in_ready}, 16'd0);
        step();
        resume = 1'b0;
        chk("resume_halted", {15'b0, halted}, 16'd0);
        chk("resume_noword", {15'b0, out_valid}, 16'd0);
        #1;
        chk("resume_ready2", {15'b0, in_ready}, 16'd1);
        step();
        chk("resume_word", {11'b0, out_valid, DA}, 16'h0011);
        in_valid = 1'b0;
        step();

        instr = 16'hA000; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        step();
        instr = 16'h0777; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp_ready%0d", k), {15'b0, in_ready}, 16'd0);
            step();
            chk($sformatf("bp_valid%0d", k), {15'b0, out_valid}, 16'd1);
            chk($sformatf("bp_ctrl%0d", k), {7'b0, ctrl_now()},
                16'b000011000);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("bp_drain", {15'b0, out_valid}, 16'd0);

        instr = 16'hB000; in_valid = 1'b1;
        #1;
        step();
        chk("br_ctrl", {6'b0, out_valid, ctrl_now()}, 16'h0206);
        out_ready = 1'b0; flush = 1'b1;
        #1;
        chk("fl_ready", {15'b0, in_ready}, 16'd0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", {15'b0, out_valid}, 16'd0);
        out_ready = 1'b1;
        step();
        chk("fl_noword", {15'b0, out_valid}, 16'd0);

        instr = 16'hFF00; in_valid = 1'b1;
        #1;
        step();
        in_valid = 1'b0;
        chk("fh_halted", {15'b0, halted}, 16'd1);
        flush = 1'b1; resume = 1'b1;
        step();
        flush = 1'b0; resume = 1'b0;
        chk("fh_run", {14'b0, halted, out_valid}, 16'd0);

        instr = 16'hFF00; in_valid = 1'b1;
        #1;
        step();
        in_valid = 1'b0;
        chk("rh_halted", {15'b0, halted}, 16'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rh_clear", {14'b0, halted, out_valid}, 16'd0);
        chk("rh_regs", {4'b0, DA, AA, BA}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
